// File: rtl/mod_pkg.sv
// Shared constants, mode encoding and per-lane correction helpers for the
// Kyber/Dilithium subtract/add butterfly arm.
package mod_pkg;

  localparam int KQ              = 3329;
  localparam int DQ              = 8380417;
  localparam int A_DELAY_DEFAULT = 6;

  localparam int KW = 12;   // Kyber lane width
  localparam int DW = 24;   // Dilithium word width / packed operand width

  typedef enum logic {
    MODE_K_SUB = 1'b0,
    MODE_D_ADD = 1'b1
  } mode_e;

  // A set borrow bit means the lane went negative; adding KQ folds it back,
  // and the sum is allowed to wrap at 12 bits.
  function automatic logic [KW-1:0] k_correct(input logic [KW:0] d);
    logic [KW-1:0] fixed;
    fixed = d[KW] ? (d[KW-1:0] + KW'(KQ)) : d[KW-1:0];
    return fixed;
  endfunction

  function automatic logic [DW-1:0] d_correct(input logic [DW:0] s);
    logic [DW-1:0] fixed;
    if (s >= (DW+1)'(DQ)) begin
      fixed = DW'(s - (DW+1)'(DQ));
    end else begin
      fixed = s[DW-1:0];
    end
    return fixed;
  endfunction

endpackage

// File: rtl/a_delay_line.sv
// Fixed-depth shift register for operand A; shifts only on an accepted input
// and exposes the oldest entry as it stood before the shift.
module a_delay_line #(
  parameter int DEPTH = 6,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] oldest
);

  logic [DEPTH:0][W-1:0] chain;

  assign chain[0] = din;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
      logic [W-1:0] tap_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tap_reg <= '0;
        end else if (shift_en) begin
          tap_reg <= chain[gi];
        end
      end

      assign chain[gi+1] = tap_reg;
    end
  endgenerate

  assign oldest = chain[DEPTH];

endmodule

// File: rtl/mod_sub_4.sv
// Dual-mode modular arm: two 12-bit subtractions mod KQ (Kyber) or one 24-bit
// addition mod DQ (Dilithium), in a two-stage valid/ready pipeline.
module mod_sub_4
  import mod_pkg::*;
#(
  parameter int A_DELAY = A_DELAY_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode,
  input  logic          sel_d_delay,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result
);

  localparam int RAW_W = 2 * (KW + 1);

  logic               s1_valid_reg;
  logic [RAW_W-1:0]   s1_raw_reg;
  mode_e              s1_mode_reg;
  logic               out_valid_reg;
  logic [DW-1:0]      result_reg;

  logic               s2_adv;
  logic               s1_adv;
  logic               in_fire;
  logic [DW-1:0]      a_old;
  logic [DW-1:0]      eff_a;
  logic [RAW_W-1:0]   s1_raw_next;
  logic [DW-1:0]      result_next;
  logic [DW:0]        d_sum;
  logic [1:0][KW:0]   k_diff;
  logic [1:0][KW-1:0] k_fix;
  logic [DW-1:0]      d_fix;

  // in_ready is combinational from out_ready so a stall release refills stage 1
  // in the same cycle.
  assign s2_adv   = !out_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && s1_adv;

  a_delay_line #(
    .DEPTH (A_DELAY),
    .W     (DW)
  ) u_a_delay (
    .clk      (clk),
    .rst      (rst),
    .shift_en (in_fire),
    .din      (a),
    .oldest   (a_old)
  );

  assign eff_a = sel_d_delay ? a_old : a;

  // Stage-1 arithmetic: independent 13-bit lane differences, or a 25-bit sum.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_k_lane
      assign k_diff[gi] = {1'b0, eff_a[gi*KW +: KW]} - {1'b0, b[gi*KW +: KW]};
      assign k_fix[gi]  = k_correct(s1_raw_reg[gi*(KW+1) +: (KW+1)]);
    end
  endgenerate

  assign d_sum = {1'b0, eff_a} + {1'b0, b};

  always_comb begin
    s1_raw_next = '0;
    if (mode_e'(mode) == MODE_D_ADD) begin
      s1_raw_next = {1'b0, d_sum};
    end else begin
      s1_raw_next = k_diff;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_raw_reg   <= '0;
      s1_mode_reg  <= MODE_K_SUB;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= in_fire;
      end
      if (in_fire) begin
        s1_raw_reg  <= s1_raw_next;
        s1_mode_reg <= mode_e'(mode);
      end
    end
  end

  // Stage-2 correction uses the mode captured alongside the data.
  assign d_fix = d_correct(s1_raw_reg[DW:0]);

  always_comb begin
    result_next = k_fix;
    if (s1_mode_reg == MODE_D_ADD) begin
      result_next = d_fix;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg <= result_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;

endmodule

// File: tb/tb_mod_sub_4.sv
// Scoreboard bench for mod_sub_4: driver pushes expected results from a
// high-level modular-arithmetic model, a monitor pops them on output transfers.
module tb_mod_sub_4;
  import mod_pkg::*;

  localparam int AD = A_DELAY_DEFAULT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mode = 1'b0;
  logic        sel_d_delay = 1'b0;
  logic [23:0] a = '0;
  logic [23:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] result;

  int checks = 0;
  int errors = 0;

  logic [23:0] sb[$];
  logic [23:0] hist[$];

  bit          stall_pending = 0;
  logic [23:0] held_result = '0;

  always #5 clk = ~clk;

  mod_sub_4 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode        (mode),
    .sel_d_delay (sel_d_delay),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h (t=%0t)", name, act, $time);
    end
  endtask

  // Golden model: plain modular arithmetic on integers.
  function automatic logic [23:0] ref_result(input bit m, input logic [23:0] aa, input logic [23:0] bb);
    longint s;
    int     hi, lo;
    if (m) begin
      s = longint'(aa) + longint'(bb);
      if (s >= longint'(DQ)) s = s - longint'(DQ);
      return 24'(s);
    end
    hi = int'(aa[23:12]) - int'(bb[23:12]);
    lo = int'(aa[11:0]) - int'(bb[11:0]);
    if (hi < 0) hi = hi + KQ;
    if (lo < 0) lo = lo + KQ;
    return {12'(hi), 12'(lo)};
  endfunction

  function automatic void accept_model(input bit m, input bit s, input logic [23:0] aa, input logic [23:0] bb);
    logic [23:0] eff;
    if (s) eff = (hist.size() == AD) ? hist[0] : 24'd0;
    else   eff = aa;
    hist.push_back(aa);
    if (hist.size() > AD) void'(hist.pop_front());
    sb.push_back(ref_result(m, eff, bb));
  endfunction

  task automatic drive(input bit v, input bit m, input bit s, input logic [23:0] aa,
                       input logic [23:0] bb, input bit ordy, output bit acc);
    @(posedge clk);
    #1;
    in_valid    = v;
    mode        = m;
    sel_d_delay = s;
    a           = aa;
    b           = bb;
    out_ready   = ordy;
    #1;
    acc = in_valid && in_ready;
    if (acc) accept_model(m, s, aa, bb);
  endtask

  task automatic send(input bit m, input bit s, input logic [23:0] aa, input logic [23:0] bb);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 64) begin
      drive(1, m, s, aa, bb, 1, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) drive(0, 0, 0, 24'd0, 24'd0, 1, acc);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every output transfer, and checks that a
  // stalled output holds steady.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_pending = 0;
      end else begin
        if (stall_pending) begin
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check("stall_hold", {8'd0, result}, {8'd0, held_result});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL result_unexpected: got %h, expected no output", result);
          end else begin
            check("result", {8'd0, result}, {8'd0, sb.pop_front()});
          end
        end
        stall_pending = out_valid && !out_ready;
        held_result   = result;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          acc;
    int          idx;
    int          acc_cnt;
    bit          m;
    bit          s;
    logic [23:0] ta, tb;
    logic [23:0] bp_a[4];
    logic [23:0] bp_b[4];

    #1 rst = 1'b0;
    #11;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {8'd0, result}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Delay line: first AD transfers see a cleared oldest entry.
    for (int i = 1; i <= 8; i++) send(1, 1, 24'(i), 24'd0);
    idle(4);

    // Kyber wrap with latency probe.
    send(0, 0, {12'd100, 12'd5}, {12'd200, 12'd5});
    idle(1);
    check("k_lat1_valid", {31'd0, out_valid}, 32'd0);
    idle(1);
    check("k_lat2_valid", {31'd0, out_valid}, 32'd1);
    check("k_wrap_result", {8'd0, result}, 32'h00C9D000);
    idle(3);

    // Dilithium wrap, back to back.
    send(1, 0, 24'd8380416, 24'd1);
    send(1, 0, 24'd8000000, 24'd400000);
    idle(1);
    check("d_wrap0_valid", {31'd0, out_valid}, 32'd1);
    check("d_wrap0_result", {8'd0, result}, 32'd0);
    idle(1);
    check("d_wrap1_valid", {31'd0, out_valid}, 32'd1);
    check("d_wrap1_result", {8'd0, result}, 32'd19583);
    idle(3);

    // Backpressure: out_ready low for 3 cycles while streaming 4 inputs.
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = {12'($urandom_range(0, KQ-1)), 12'($urandom_range(0, KQ-1))};
      bp_b[i] = {12'($urandom_range(0, KQ-1)), 12'($urandom_range(0, KQ-1))};
    end
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, bp_a[idx], bp_b[idx], 0, acc);
      if (acc) idx++;
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    if (in_valid && in_ready) begin
      accept_model(0, 0, bp_a[idx], bp_b[idx]);
      idx++;
    end
    while (idx < 4) begin
      send(0, 0, bp_a[idx], bp_b[idx]);
      idx++;
    end
    drain("bp_drain");

    // Mixed modes every cycle, no bubbles expected.
    acc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      m = i[0];
      if (m) begin
        ta = 24'($urandom_range(0, DQ-1));
        tb = 24'($urandom_range(0, DQ-1));
      end else begin
        ta = {12'($urandom_range(0, KQ-1)), 12'($urandom_range(0, KQ-1))};
        tb = {12'($urandom_range(0, KQ-1)), 12'($urandom_range(0, KQ-1))};
      end
      drive(1, m, 0, ta, tb, 1, acc);
      if (acc) acc_cnt++;
    end
    check("mixed_no_bubble", acc_cnt, 40);
    drain("mixed_drain");

    // Random traffic with random backpressure, delay select, and some
    // out-of-range operands.
    for (int i = 0; i < 200; i++) begin
      m = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        ta = 24'($urandom);
        tb = 24'($urandom);
      end else if (m) begin
        ta = 24'($urandom_range(0, DQ-1));
        tb = 24'($urandom_range(0, DQ-1));
      end else begin
        ta = {12'($urandom_range(0, KQ-1)), 12'($urandom_range(0, KQ-1))};
        tb = {12'($urandom_range(0, KQ-1)), 12'($urandom_range(0, KQ-1))};
      end
      drive(($urandom_range(0, 3) != 0), m, s, ta, tb, ($urandom_range(0, 3) != 0), acc);
    end
    drain("rand_drain");

    // Reset mid-stream with both stages occupied.
    drive(1, 0, 0, 24'h123456, 24'h000111, 0, acc);
    drive(1, 1, 0, 24'h000100, 24'h000200, 0, acc);
    drive(0, 0, 0, 24'd0, 24'd0, 0, acc);
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", {8'd0, result}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    hist.delete();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Delay line must be cleared: effective A is 0.
    send(0, 1, {12'd7, 12'd9}, {12'd1, 12'd3328});
    idle(1);
    check("post_rst_lat1_valid", {31'd0, out_valid}, 32'd0);
    idle(1);
    check("post_rst_lat2_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_result", {8'd0, result}, 32'h00D00001);
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
